// File: rtl/sram_stream_ctrl.sv
// Streaming burst controller for a single-port synchronous SRAM macro.
// A configured burst (base, length, direction) becomes one SRAM access per
// cycle at most. Writes are fed from a valid/ready stream; reads return
// through a small FIFO to a valid/ready stream with full backpressure.
module sram_stream_ctrl #(
  parameter int NUM_WORD   = 2048,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RSTB,
  // burst configuration
  input  logic              cfg_start,
  input  logic              cfg_mode,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_len,
  output logic              busy,
  output logic              done,
  // write stream
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  // read stream
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  // SRAM macro
  output logic              CEB,
  output logic              WEB,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = OW + 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                done_q, done_d;

  logic                ceb_q, ceb_d;
  logic                web_q, web_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   d_q, d_d;

  // issue decision travels two stages before Q is captured
  logic [2:1]          vld_pipe_q;
  logic [1:0]          inflight;

  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       rptr_q, wptr_q;
  logic [OW-1:0]       occ_q;

  logic                wr_hs, issue, push, pop, room;
  logic [ADDR_W-1:0]   addr_inc;
  logic [LW-1:0]       level;

  assign inflight = {1'b0, vld_pipe_q[1]} + {1'b0, vld_pipe_q[2]};
  assign push     = vld_pipe_q[2];
  assign rd_valid = (occ_q != '0);
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = rd_valid ? fifo_mem[rptr_q] : '0;

  // Only issue a read if every word already owed to the FIFO still fits
  // after this cycle's pop, so a captured word always has a slot.
  assign level = LW'(occ_q) + LW'(inflight);
  assign room  = level < (LW'(FIFO_DEPTH) + LW'(pop));

  // Explicit wrap at the top of the array, equivalent to modulo 2^ADDR_W
  // for a power-of-two depth.
  assign addr_inc = (addr_q == ADDR_W'(NUM_WORD - 1)) ? '0 : addr_q + ADDR_W'(1);

  assign wr_ready = (state_q == WRITE) && (rem_q != '0);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign CEB      = ceb_q;
  assign WEB      = web_q;
  assign A        = a_q;
  assign D        = d_q;

  // Burst FSM: next state, address/remaining counters, done pulse
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    wr_hs   = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          addr_d = cfg_base;
          rem_d  = cfg_len;
          if (cfg_len == '0) done_d = 1'b1;
          else               state_d = cfg_mode ? READ : WRITE;
        end
      end
      WRITE: begin
        if (rem_q != '0) begin
          if (wr_valid) begin
            wr_hs  = 1'b1;
            addr_d = addr_inc;
            rem_d  = rem_q - (ADDR_W+1)'(1);
          end
        end else begin
          // this cycle carries the last strobe
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      READ: begin
        if (rem_q == '0) begin
          state_d = DRAIN;
        end else if (room) begin
          issue  = 1'b1;
          addr_d = addr_inc;
          rem_d  = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0 && (occ_q == '0 || (occ_q == OW'(1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // SRAM pin next values: one access per cycle, address/data hold when idle
  always_comb begin
    ceb_d = ~(wr_hs | issue);
    web_d = ~wr_hs;
    a_d   = (wr_hs | issue) ? addr_q : a_q;
    d_d   = wr_hs ? wr_data : d_q;
  end

  // Registered SRAM pins
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      ceb_q <= 1'b1;
      web_q <= 1'b1;
      a_q   <= '0;
      d_q   <= '0;
    end else begin
      ceb_q <= ceb_d;
      web_q <= web_d;
      a_q   <= a_d;
      d_q   <= d_d;
    end
  end

  // Read-return pipeline: a reset drops outstanding reads
  always_ff @(posedge CLK) begin
    if (!RSTB) vld_pipe_q <= '0;
    else       vld_pipe_q <= {vld_pipe_q[1], issue};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (pop)  rptr_q <= (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      occ_q <= occ_q + OW'(push) - OW'(pop);
    end
  end

  // FIFO storage; contents are don't-care while the entry is unoccupied
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wptr_q] <= Q;
  end

endmodule
